instr_issue_queue: RTL and testbench
====================================

# instr_issue_queue

Instruction buffer and issue sequencer directly upstream of the 16-bit accumulator datapath. It accepts instructions from a host through a valid/ready handshake and stores them in a DEPTH-entry FIFO. It then presents them to the datapath's `instruction_in`/`instruction_valid` inputs as single-cycle pulses, spaced at least ISSUE_GAP cycles apart, so that each opcode/immediate latch, controller decode and regc capture completes before the next instruction arrives. It also provides flush, run/stall gating and an issued-instruction counter for debug.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- ISSUE_GAP, 2: minimum cycles between consecutive issue pulses; 1..15.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- host_data  input  16  instruction word from host ([15:10] opcode, [9:0] immediate).
- host_valid  input  1  host_data valid.
- host_ready  output  1  queue can accept a word; equals !full.
- flush  input  1  synchronous clear of queue and sequencer.
- run  input  1  issue enable; 0 stalls issue without affecting push.
- instr_out  output  16  instruction to datapath (`instruction_in`).
- instr_valid  output  1  one-cycle issue pulse (`instruction_valid`).
- count  output  $clog2(DEPTH)+1  entries currently stored.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- issued_count  output  16  total instructions issued since reset/flush; wraps 0xFFFF -> 0x0000.

## Operation
- **FIFO:** circular buffer with write and read pointers of $clog2(DEPTH) bits that wrap naturally, plus a separate count register. The state flags are derived from the registered count.
- **Push:** occurs when host_valid && host_ready && !flush at a rising edge. host_data is written at the write pointer, which then increments.
- **Full and simultaneous pop:** host_ready is based on registered full only. When full, a push is refused even if a pop happens in the same cycle. The host must hold host_data/host_valid until accepted.
- **Sequencer FSM states:**
  - IDLE: no gap pending.
  - GAP: gap counter running.
- **Issue condition (from IDLE):** at an edge with run=1, count!=0 and flush=0:
  - pop the head;
  - register it into instr_out;
  - set instr_valid=1;
  - increment issued_count.
- **Transition after issue:**
  - ISSUE_GAP=1: stay in IDLE, so back-to-back issues are allowed.
  - Otherwise: enter GAP with gap_cnt = ISSUE_GAP-1.
- **GAP state:** gap_cnt decrements each edge; at 1 the FSM returns to IDLE. No issue occurs while in GAP. The gap counter runs regardless of run.
- **instr_valid clearing:** instr_valid clears at the next edge unless another issue occurs at that edge. instr_out holds the last issued word while instr_valid=0.
- **Simultaneous push and pop:** both take effect; count is unchanged.
- **No bypass:** a word pushed into an empty queue is not issuable until the following edge.
- **Flush:** flush=1 at an edge does all of the following:
  - zeros both pointers, count and issued_count;
  - forces the FSM to IDLE;
  - clears instr_valid;
  - leaves instr_out unchanged.
  - Flush beats push and issue in the same cycle.
- **run deasserted:** no new issue; queue contents and an in-progress gap are unaffected.

## Timing
- **Reset values:**
  - instr_out=0x0000, instr_valid=0;
  - count=0, empty=1, full=0, host_ready=1;
  - issued_count=0;
  - FSM=IDLE, pointers=0.
- **Reset mid-operation:** all state, including queued entries, returns to the reset values immediately on rst assertion. Operation resumes on the first edge after rst deasserts.
- **Push-to-issue latency:** a word pushed at edge k into an empty queue, with run=1 and FSM=IDLE, is on instr_out with instr_valid=1 in the cycle after edge k+1.
- **Issue spacing:** issue pulses are exactly ISSUE_GAP cycles apart while the queue is non-empty and run=1.
- **Flag timing:** count, empty and full update on the same edge as the push/pop that changes them.
- **Pulse width:** instr_valid is never high for more than one cycle per entry.

## Test plan
- **Reset:** assert rst mid-cycle -> instr_valid=0, instr_out=0x0000, count=0, empty=1, host_ready=1 immediately.
- **Basic issue:** ISSUE_GAP=2, run=1; push 0x0405, 0x0803, 0x1C00 on consecutive edges -> pulses at cycles t, t+2, t+4 carrying those words in order; issued_count=3; empty=1 after the last pop.
- **Full:** DEPTH=8, run=0; push 9 words 0x0001..0x0009 -> after 8 accepted, full=1, host_ready=0 and the 9th is held. Set run=1 -> the first pop occurs and 0x0009 is accepted on the edge after full drops; all 9 issue in order.
- **Back-to-back:** ISSUE_GAP=1; preload 4 words, then run=1 -> instr_valid high 4 consecutive cycles with correct words, then low.
- **Flush:** flush with 3 words queued, in the GAP state and while pushing -> count=0, instr_valid=0, issued_count=0, the push is dropped, and no further pulses occur.
- **Stall:** deassert run between issues with 2 words queued -> no pulses and count stays 2. Reassert run -> issue resumes on the next edge (the gap has already elapsed).

Source files
------------

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: host FIFO feeding the accumulator datapath with gap-spaced single-cycle issue pulses.
module instr_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int ISSUE_GAP = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                host_data,
    input  logic                       host_valid,
    output logic                       host_ready,
    input  logic                       flush,
    input  logic                       run,
    output logic [15:0]                instr_out,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic [15:0]                issued_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = 4;
    typedef enum logic {IDLE, GAP} state_t;
    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     out_q, out_d, issued_q, issued_d;
    logic            valid_q, valid_d;
    logic [15:0]     mem_q [DEPTH];
    logic            push, pop;
    assign full         = count_q == CW'(DEPTH);
    assign empty        = count_q == '0;
    assign host_ready   = !full;
    assign count        = count_q;
    assign instr_out    = out_q;
    assign instr_valid  = valid_q;
    assign issued_count = issued_q;
    // Both decisions use registered state only, so a word pushed this edge is never popped this edge.
    assign push = host_valid && !full && !flush;
    assign pop  = state_q == IDLE && run && !empty && !flush;
    always_comb begin
        state_d  = flush ? IDLE : pop ? (ISSUE_GAP == 1 ? IDLE : GAP)
                 : (state_q == GAP && gap_q == GW'(1)) ? IDLE : state_q;
        gap_d    = flush ? '0 : pop ? GW'(ISSUE_GAP - 1) : state_q == GAP ? gap_q - GW'(1) : gap_q;
        wptr_d   = flush ? '0 : wptr_q + AW'(push);
        rptr_d   = flush ? '0 : rptr_q + AW'(pop);
        count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
        issued_d = flush ? '0 : issued_q + 16'(pop);
        out_d    = pop ? mem_q[rptr_q] : out_q;
        valid_d  = pop;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
        end
    end
    // Storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= host_data;
    end
endmodule

// File: tb/tb_instr_issue_queue.sv
// tb_instr_issue_queue: directed checks on a gap-2 queue and a gap-1 queue sharing one stimulus stream.
module tb_instr_issue_queue;
    logic        clk, rst, host_valid, flush, run;
    logic [15:0] host_data;
    logic        a_ready, a_valid, a_empty, a_full;
    logic [15:0] a_out, a_issued;
    logic [3:0]  a_count;
    logic        b_ready, b_valid, b_empty, b_full;
    logic [15:0] b_out, b_issued;
    logic [3:0]  b_count;
    int checks = 0;
    int errors = 0;

    instr_issue_queue #(.DEPTH(8), .ISSUE_GAP(2)) dut_a (
        .clk(clk), .rst(rst), .host_data(host_data), .host_valid(host_valid), .host_ready(a_ready),
        .flush(flush), .run(run), .instr_out(a_out), .instr_valid(a_valid), .count(a_count),
        .empty(a_empty), .full(a_full), .issued_count(a_issued));

    instr_issue_queue #(.DEPTH(8), .ISSUE_GAP(1)) dut_b (
        .clk(clk), .rst(rst), .host_data(host_data), .host_valid(host_valid), .host_ready(b_ready),
        .flush(flush), .run(run), .instr_out(b_out), .instr_valid(b_valid), .count(b_count),
        .empty(b_empty), .full(b_full), .issued_count(b_issued));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1; host_valid = 0; run = 0;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; run = 0; host_valid = 0; host_data = 0;
        tick(); tick();
        checks++; if (a_valid !== 1'b0 || a_out !== 16'h0) begin errors++; $display("FAIL reset_out got v=%b o=%h exp v=0 o=0000", a_valid, a_out); end
        checks++; if (a_count !== 4'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_ready !== 1'b1) begin errors++; $display("FAIL reset_flags got c=%0d e=%b f=%b r=%b exp c=0 e=1 f=0 r=1", a_count, a_empty, a_full, a_ready); end
        checks++; if (a_issued !== 16'd0) begin errors++; $display("FAIL reset_issued got %0d exp 0", a_issued); end
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] w [3];
        w[0] = 16'h0405; w[1] = 16'h0803; w[2] = 16'h1C00;
        do_flush();
        run = 1; host_valid = 1; host_data = w[0];
        tick();
        host_data = w[1];
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== w[0]) begin errors++; $display("FAIL basic_p0 got v=%b o=%h exp v=1 o=%h", a_valid, a_out, w[0]); end
        host_data = w[2];
        tick();
        host_valid = 0;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_gap0 got v=%b exp 0", a_valid); end
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== w[1]) begin errors++; $display("FAIL basic_p1 got v=%b o=%h exp v=1 o=%h", a_valid, a_out, w[1]); end
        tick();
        checks++; if (a_valid !== 1'b0 || a_out !== w[1]) begin errors++; $display("FAIL basic_hold got v=%b o=%h exp v=0 o=%h", a_valid, a_out, w[1]); end
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== w[2]) begin errors++; $display("FAIL basic_p2 got v=%b o=%h exp v=1 o=%h", a_valid, a_out, w[2]); end
        checks++; if (a_issued !== 16'd3 || a_empty !== 1'b1 || a_count !== 4'd0) begin errors++; $display("FAIL basic_end got iss=%0d e=%b c=%0d exp iss=3 e=1 c=0", a_issued, a_empty, a_count); end
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL basic_tail got v=%b exp 0", a_valid); end
    endtask

    task automatic test_full();
        logic [15:0] exp;
        do_flush();
        run = 0; host_valid = 1;
        for (int i = 1; i <= 9; i++) begin
            host_data = 16'(i);
            tick();
        end
        checks++; if (a_count !== 4'd8 || a_full !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL full_flags got c=%0d f=%b r=%b exp c=8 f=1 r=0", a_count, a_full, a_ready); end
        run = 1;
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== 16'h0001 || a_count !== 4'd7 || a_full !== 1'b0) begin errors++; $display("FAIL full_pop got v=%b o=%h c=%0d f=%b exp v=1 o=0001 c=7 f=0", a_valid, a_out, a_count, a_full); end
        tick();
        host_valid = 0;
        checks++; if (a_count !== 4'd8 || a_full !== 1'b1) begin errors++; $display("FAIL full_accept9 got c=%0d f=%b exp c=8 f=1", a_count, a_full); end
        exp = 16'h0002;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (a_valid) begin
                checks++; if (a_out !== exp) begin errors++; $display("FAIL full_order got %h exp %h", a_out, exp); end
                exp++;
            end
        end
        checks++; if (exp !== 16'h000A || a_issued !== 16'd9 || a_empty !== 1'b1) begin errors++; $display("FAIL full_drain got next=%h iss=%0d e=%b exp next=000a iss=9 e=1", exp, a_issued, a_empty); end
    endtask

    task automatic test_back_to_back();
        do_flush();
        host_valid = 1;
        for (int i = 1; i <= 4; i++) begin
            host_data = 16'h0A00 + 16'(i);
            tick();
        end
        host_valid = 0; run = 1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (b_valid !== 1'b1 || b_out !== 16'h0A00 + 16'(i)) begin errors++; $display("FAIL b2b_p%0d got v=%b o=%h exp v=1 o=%h", i, b_valid, b_out, 16'h0A00 + 16'(i)); end
        end
        tick();
        checks++; if (b_valid !== 1'b0 || b_issued !== 16'd4) begin errors++; $display("FAIL b2b_end got v=%b iss=%0d exp v=0 iss=4", b_valid, b_issued); end
    endtask

    task automatic test_flush();
        int pulses;
        do_flush();
        host_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            host_data = 16'h0B00 + 16'(i);
            tick();
        end
        run = 1; host_data = 16'h0B04;
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== 16'h0B01 || a_count !== 4'd3) begin errors++; $display("FAIL flush_pre got v=%b o=%h c=%0d exp v=1 o=0b01 c=3", a_valid, a_out, a_count); end
        flush = 1; host_data = 16'h0B05;
        tick();
        flush = 0; host_valid = 0;
        checks++; if (a_count !== 4'd0 || a_valid !== 1'b0 || a_issued !== 16'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL flush_clear got c=%0d v=%b iss=%0d e=%b exp c=0 v=0 iss=0 e=1", a_count, a_valid, a_issued, a_empty); end
        checks++; if (a_out !== 16'h0B01) begin errors++; $display("FAIL flush_out_hold got %h exp 0b01", a_out); end
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (a_valid) pulses++;
        end
        checks++; if (pulses !== 0 || a_count !== 4'd0) begin errors++; $display("FAIL flush_quiet got pulses=%0d c=%0d exp pulses=0 c=0", pulses, a_count); end
    endtask

    task automatic test_stall();
        int pulses;
        do_flush();
        host_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            host_data = 16'h0C00 + 16'(i);
            tick();
        end
        host_valid = 0; run = 1;
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== 16'h0C01) begin errors++; $display("FAIL stall_first got v=%b o=%h exp v=1 o=0c01", a_valid, a_out); end
        run = 0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (a_valid) pulses++;
        end
        checks++; if (pulses !== 0 || a_count !== 4'd2) begin errors++; $display("FAIL stall_hold got pulses=%0d c=%0d exp pulses=0 c=2", pulses, a_count); end
        run = 1;
        tick();
        checks++; if (a_valid !== 1'b1 || a_out !== 16'h0C02 || a_count !== 4'd1) begin errors++; $display("FAIL stall_resume got v=%b o=%h c=%0d exp v=1 o=0c02 c=1", a_valid, a_out, a_count); end
    endtask

    task automatic test_reset_mid();
        run = 0; host_valid = 1; host_data = 16'h0D01;
        tick(); tick();
        host_valid = 0;
        @(posedge clk);
        #3 rst = 1;
        #1;
        checks++; if (a_valid !== 1'b0 || a_out !== 16'h0 || a_count !== 4'd0 || a_empty !== 1'b1 || a_ready !== 1'b1 || a_issued !== 16'd0) begin errors++; $display("FAIL reset_mid got v=%b o=%h c=%0d e=%b r=%b iss=%0d exp v=0 o=0000 c=0 e=1 r=1 iss=0", a_valid, a_out, a_count, a_empty, a_ready, a_issued); end
        tick();
        rst = 0; run = 1;
        tick(); tick(); tick();
        checks++; if (a_valid !== 1'b0 || a_count !== 4'd0 || a_issued !== 16'd0) begin errors++; $display("FAIL reset_mid_after got v=%b c=%0d iss=%0d exp v=0 c=0 iss=0", a_valid, a_count, a_issued); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_flush();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
